// File: rtl/gomoku_pkg.sv
// gomoku_pkg: shared board defaults and the cell, status and direction encodings
package gomoku_pkg;
  localparam int DEF_BOARD_N = 6;
  localparam int DEF_WIN_LEN = 5;
  typedef enum logic [1:0] {EMPTY = 2'd0, P1 = 2'd1, P2 = 2'd2} cell_t;
  typedef enum logic [1:0] {NONE = 2'd0, P1_WIN = 2'd1, P2_WIN = 2'd2, DRAW = 2'd3} status_t;
  typedef enum logic [1:0] {RIGHT = 2'd0, DOWN = 2'd1, DOWN_RIGHT = 2'd2, DOWN_LEFT = 2'd3} dir_t;
endpackage

// File: rtl/line_match.sv
// line_match: checks whether WIN_LEN same-player stones run from one cell along one direction
module line_match
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = DEF_BOARD_N,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic [2*BOARD_N*BOARD_N-1:0]         i_snap,
  input  logic [$clog2(BOARD_N*BOARD_N)-1:0]   i_cell,
  input  dir_t                                 i_dir,
  output logic                                 o_match,
  output logic [1:0]                           o_player
);
  localparam int NN = BOARD_N * BOARD_N;
  localparam int CW = $clog2(NN);
  logic [1:0] w_cells [NN];
  logic [1:0] w_first;
  logic       w_ok;
  int         w_row, w_col, w_dr, w_dc;
  for (genvar g = 0; g < NN; g++) begin : g_cells
    assign w_cells[g] = i_snap[2*g +: 2];
  end
  // walk the run; any cell off the board or differing from the start cell kills the match
  always_comb begin
    w_row   = int'(i_cell) / BOARD_N;
    w_col   = int'(i_cell) % BOARD_N;
    w_dr    = (i_dir == RIGHT) ? 0 : 1;
    w_dc    = (i_dir == DOWN) ? 0 : (i_dir == DOWN_LEFT) ? -1 : 1;
    w_first = w_cells[i_cell];
    w_ok    = (w_first == P1) || (w_first == P2);
    for (int k = 1; k < WIN_LEN; k++) begin
      if (w_row + k*w_dr >= BOARD_N || w_col + k*w_dc < 0 || w_col + k*w_dc >= BOARD_N) w_ok = 1'b0;
      else if (w_cells[CW'((w_row + k*w_dr)*BOARD_N + w_col + k*w_dc)] != w_first) w_ok = 1'b0;
    end
  end
  assign o_match  = w_ok;
  assign o_player = w_ok ? w_first : 2'd0;
endmodule

// File: rtl/win_scanner.sv
// win_scanner: sequential (cell, direction) win search over a board snapshot; WIN_SCANNER_DRAW_EN adds draw detection
module win_scanner
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = DEF_BOARD_N,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2*BOARD_N*BOARD_N-1:0] board,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   status
);
  localparam int NN = BOARD_N * BOARD_N;
  localparam int CW = $clog2(NN);
  localparam int PW = CW + 2;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t              r_state, w_next;
  logic [2*NN-1:0]     r_snap;
  logic [PW-1:0]       r_idx;
  logic                r_done;
  logic [1:0]          r_status;
  logic                w_accept, w_last, w_fin, w_match;
  logic [1:0]          w_player, w_nomatch;
  line_match #(.BOARD_N(BOARD_N), .WIN_LEN(WIN_LEN)) u_line (
    .i_snap   (r_snap),
    .i_cell   (r_idx[PW-1:2]),
    .i_dir    (dir_t'(r_idx[1:0])),
    .o_match  (w_match),
    .o_player (w_player)
  );
`ifdef WIN_SCANNER_DRAW_EN
  logic [NN-1:0] w_empty;
  for (genvar g = 0; g < NN; g++) begin : g_full
    assign w_empty[g] = !(r_snap[2*g +: 2] == P1 || r_snap[2*g +: 2] == P2);
  end
  assign w_nomatch = ~|w_empty ? DRAW : NONE;
`else
  assign w_nomatch = NONE;
`endif
  // a start landing on the done cycle is dropped so each result is seen once
  always_comb begin
    w_accept = (r_state == IDLE) && start && !r_done;
    w_last   = r_idx == PW'(4*NN-1);
    w_fin    = (r_state == SCAN) && (w_match || w_last);
    w_next   = (r_state == IDLE) ? (w_accept ? SCAN : IDLE) : (w_fin ? IDLE : SCAN);
  end
  // control state, done pulse and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_done   <= 1'b0;
      r_status <= NONE;
    end else begin
      r_state  <= w_next;
      r_done   <= w_fin;
      if (w_accept) r_status <= NONE;
      else if (w_fin) r_status <= w_match ? w_player : w_nomatch;
    end
  end
  // snapshot and pair index carry no reset; they are rewritten on every accepted start
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_snap <= board;
      r_idx  <= '0;
    end else if (r_state == SCAN) r_idx <= r_idx + 1'b1;
  end
  assign busy   = r_state == SCAN;
  assign done   = r_done;
  assign status = r_status;
endmodule

// File: tb/tb_win_scanner.sv
// tb_win_scanner: directed scans with hand-computed done cycles and results
module tb_win_scanner;
  localparam int BW = 72;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [BW-1:0] board = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [1:0]    status;
  int            n_checks = 0;
  int            n_fail = 0;
  win_scanner dut (
    .clk    (clk),
    .rst    (rst),
    .board  (board),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .status (status)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [BW-1:0] run5(input logic [BW-1:0] b, input int c0, input int step, input logic [1:0] v);
    logic [BW-1:0] r = b;
    for (int k = 0; k < 5; k++) r[7'(2*(c0 + k*step)) +: 2] = v;
    return r;
  endfunction
  function automatic logic [BW-1:0] full_board();
    logic [BW-1:0] r = '0;
    for (int rr = 0; rr < 6; rr++)
      for (int cc = 0; cc < 6; cc++)
        r[7'(2*(rr*6 + cc)) +: 2] = 2'(1 + ((cc/2 + rr) % 2));
    return r;
  endfunction
  // start at cycle 0 (negedge), then sample every negedge up to a few cycles past the expected done
  task automatic scan(input string tag, input logic [BW-1:0] b, input int exp_st, input int exp_done, input int extra);
    int dc = 0, nd = 0, berr = 0, st1 = -1;
    board = b;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= exp_done + 3; c++) begin
      start = 1'b0;
      if (c == 1) st1 = int'(status);
      if (busy !== (c < exp_done)) berr++;
      if (done === 1'b1) begin
        nd++;
        if (dc == 0) dc = c;
      end
      if (c == 3) board = '1;
      if (c == extra) start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " status_clr"}, st1, 0);
    check({tag, " done_cycle"}, dc, exp_done);
    check({tag, " done_count"}, nd, 1);
    check({tag, " busy_errs"}, berr, 0);
    check({tag, " status"}, int'(status), exp_st);
  endtask
  initial begin
    int nd;
    logic [BW-1:0] b;
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset status", int'(status), 0);
    rst = 1'b0;
    @(negedge clk);
    scan("empty", '0, 0, 145, 0);
    scan("row_p1", run5('0, 0, 1, 2'd1), 1, 2, 2);
    scan("diag_dl_p2", run5('0, 5, 5, 2'd2), 2, 25, 0);
    scan("col_p1", run5('0, 11, 6, 2'd1), 1, 47, 0);
    scan("diag_dr_p2", run5('0, 7, 7, 2'd2), 2, 32, 0);
    scan("wrap", run5('0, 3, 1, 2'd1), 0, 145, 10);
`ifdef WIN_SCANNER_DRAW_EN
    scan("full", full_board(), 3, 145, 0);
`else
    scan("full", full_board(), 0, 145, 0);
`endif
    scan("all_three", '1, 0, 145, 0);
    b = run5('0, 30, 1, 2'd2);
    board = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid status", int'(status), 0);
    check("rst_mid done", int'(done), 0);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 150; c++) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    check("rst_mid no_done", nd, 0);
    check("rst_mid status_hold", int'(status), 0);
    scan("after_rst", b, 2, 122, 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
